// File: rtl/pe_mac_sequencer_if.sv
// pe_mac_sequencer_if: operand-memory read port, PE operand/MAC controls and output handshake.
interface pe_mac_sequencer_if #(parameter int ADDR_W = 16);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       datain;
    logic [2:0]        latency_counter;
    logic              write_mat;
    logic              mat_mux;
    logic              rst_add;
    logic              mac_ctrl;
    logic              rst_acc;
    logic              rst_pc;
    logic              mac_done;
    logic [1:0]        dimen_pe;
    logic              out_ready;
    logic              out_ack;

    modport master (
        output mem_rd, mem_addr, datain, latency_counter, write_mat, mat_mux, rst_add,
               mac_ctrl, rst_acc, rst_pc, dimen_pe, out_ready,
        input  mem_rdata, mac_done, out_ack
    );
    modport slave (
        input  mem_rd, mem_addr, datain, latency_counter, write_mat, mat_mux, rst_add,
               mac_ctrl, rst_acc, rst_pc, dimen_pe, out_ready,
        output mem_rdata, mac_done, out_ack
    );
endinterface

// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: fetches A and B vectors into the PE operand buffers, runs the MAC,
// then holds the result until acknowledged and pulses done.
module pe_mac_sequencer #(
    parameter int N      = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_dimen,
    input  logic [ADDR_W-1:0] i_a_base,
    input  logic [ADDR_W-1:0] i_b_base,
    input  logic [ADDR_W-1:0] i_b_stride,
    output logic              o_busy,
    output logic              o_done,
    pe_mac_sequencer_if.master bus
);
    localparam int IW = $clog2(N) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR_A  = 3'd1;
    localparam logic [2:0] S_LOAD_A = 3'd2;
    localparam logic [2:0] S_CLR_B  = 3'd3;
    localparam logic [2:0] S_LOAD_B = 3'd4;
    localparam logic [2:0] S_MAC    = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    logic [2:0]        r_state;
    logic [1:0]        r_dimen;
    logic [ADDR_W-1:0] r_b_base;
    logic [ADDR_W-1:0] r_b_stride;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [2:0]        r_lat;
    logic [IW-1:0]     r_idx;

    logic [2:0]    w_next;
    logic [IW-1:0] w_len;
    logic          w_load;
    logic          w_clr;
    logic          w_step;
    logic          w_last;

    assign w_len  = IW'(2) << r_dimen;
    assign w_load = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_clr  = (r_state == S_CLR_A) || (r_state == S_CLR_B);
    assign w_step = w_load && (r_lat == 3'd2);
    assign w_last = w_step && (r_idx == w_len - IW'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_start ? S_CLR_A : S_IDLE;
            S_CLR_A:  w_next = S_LOAD_A;
            S_LOAD_A: w_next = w_last ? S_CLR_B : S_LOAD_A;
            S_CLR_B:  w_next = S_LOAD_B;
            S_LOAD_B: w_next = w_last ? S_MAC : S_LOAD_B;
            S_MAC:    w_next = bus.mac_done ? S_OUT : S_MAC;
            S_OUT:    w_next = bus.out_ack ? S_FIN : S_OUT;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_addr walks A by 1, then is reloaded with B_BASE and walks B by the stride
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dimen     <= '0;
            r_b_base    <= '0;
            r_b_stride  <= '0;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_lat       <= '0;
            r_idx       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start) begin
                r_dimen    <= i_dimen;
                r_b_base   <= i_b_base;
                r_b_stride <= i_b_stride;
                r_addr     <= i_a_base;
            end
            if (w_clr) begin
                r_lat <= '0;
                r_idx <= '0;
            end else if (w_load) begin
                r_lat <= (r_lat == 3'd2) ? 3'd0 : r_lat + 3'd1;
                if (w_step) r_idx <= r_idx + IW'(1);
            end
            if (r_state == S_CLR_B) r_addr <= r_b_base;
            else if (w_step) r_addr <= r_addr + ((r_state == S_LOAD_A) ? ADDR_W'(1) : r_b_stride);
            if (bus.mem_rd) r_last_addr <= r_addr;
        end
    end

    assign bus.mem_rd          = w_load && (r_lat == 3'd0);
    assign bus.mem_addr        = bus.mem_rd ? r_addr : r_last_addr;
    assign bus.datain          = bus.mem_rdata;
    assign bus.latency_counter = r_lat;
    assign bus.write_mat       = w_load;
    assign bus.mat_mux         = (r_state == S_CLR_A) || (r_state == S_LOAD_A);
    assign bus.rst_add         = w_clr;
    assign bus.rst_acc         = (r_state == S_CLR_A);
    assign bus.rst_pc          = (r_state == S_CLR_A);
    assign bus.mac_ctrl        = (r_state == S_MAC) && !bus.mac_done;
    assign bus.dimen_pe        = r_dimen;
    assign bus.out_ready       = (r_state == S_OUT);
    assign o_busy              = (r_state != S_IDLE);
    assign o_done              = (r_state == S_FIN);
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// tb_pe_mac_sequencer: drives operations against a memory with 2-cycle read latency and a
// behavioural PE, checking results, read addresses and cycle timing against a dot-product model.
module tb_pe_mac_sequencer;
    typedef struct {
        int dimen; int a; int b; int s; int ack_dly; int fill; int exp; int use_exp; int flags;
    } vec_t;

    logic        clk = 0, rst_n = 0, start = 0, ack = 0;
    logic [1:0]  dimen = 0;
    logic [15:0] a_base = 0, b_base = 0, b_stride = 0;
    logic        busy, done;
    int          checks = 0, errors = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] p1, p2;
    logic [31:0] pe_a [0:15];
    logic [31:0] pe_b [0:15];
    logic [4:0]  wa, pc;
    logic [31:0] acc;
    logic [15:0] addr_q[$];
    int          mac_cnt = 0, done_cnt = 0, overlap = 0;

    pe_mac_sequencer_if #(.ADDR_W(16)) bus();

    pe_mac_sequencer #(.N(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_dimen(dimen), .i_a_base(a_base),
        .i_b_base(b_base), .i_b_stride(b_stride), .o_busy(busy), .o_done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1 <= bus.mem_rd ? mem[bus.mem_addr] : 32'hDEADBEEF;
        p2 <= p1;
    end
    assign bus.mem_rdata = p2;
    assign bus.out_ack   = ack;
    assign bus.mac_done  = (pc == (5'd2 << bus.dimen_pe));

    always @(posedge clk) begin
        if (bus.rst_add) wa <= 0;
        else if (bus.write_mat && bus.latency_counter == 3'd2) begin
            if (bus.mat_mux) pe_a[wa[3:0]] <= bus.datain;
            else pe_b[wa[3:0]] <= bus.datain;
            wa <= wa + 5'd1;
        end
        if (bus.rst_acc) acc <= 0;
        else if (bus.mac_ctrl) acc <= acc + pe_a[pc[3:0]] * pe_b[pc[3:0]];
        if (bus.rst_pc) pc <= 0;
        else if (bus.mac_ctrl) pc <= pc + 5'd1;
    end

    always @(negedge clk) begin
        if (bus.mem_rd) addr_q.push_back(bus.mem_addr);
        if (bus.mac_ctrl) mac_cnt++;
        if (done) done_cnt++;
        if (bus.rst_add && bus.write_mat) overlap++;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] model_dot(input int dm, input logic [15:0] a, b, s);
        logic [31:0] sum;
        sum = 0;
        for (int i = 0; i < (2 << dm); i++) sum += mem[a + 16'(i)] * mem[16'(b + 16'(i) * s)];
        return sum;
    endfunction

    task automatic fill(input vec_t v);
        logic [15:0] a, b, s;
        a = 16'(v.a); b = 16'(v.b); s = 16'(v.s);
        for (int i = 0; i < (2 << v.dimen); i++) begin
            case (v.fill)
                0:       begin mem[a + 16'(i)] = (i == 0) ? 3 : 5; mem[16'(b + 16'(i) * s)] = (i == 0) ? 7 : 11; end
                1:       begin mem[a + 16'(i)] = i; mem[16'(b + 16'(i) * s)] = 2; end
                2:       begin mem[a + 16'(i)] = 1; mem[16'(b + 16'(i) * s)] = 1; end
                default: begin mem[a + 16'(i)] = $urandom; mem[16'(b + 16'(i) * s)] = $urandom; end
            endcase
        end
    endtask

    task automatic zero_outputs(input string nm);
        chk(nm, {bus.mem_rd, bus.mem_addr, bus.latency_counter, bus.write_mat, bus.mat_mux,
                 bus.rst_add, bus.mac_ctrl, bus.rst_acc, bus.rst_pc, bus.dimen_pe,
                 bus.out_ready, busy, done}, 0);
        chk({nm, "_datain"}, bus.datain, bus.mem_rdata);
    endtask

    task automatic run_op(input vec_t v);
        int          len, n, bad, first;
        logic [31:0] want, held;
        logic [15:0] exp_q[$];
        len  = 2 << v.dimen;
        fill(v);
        want = v.use_exp ? 32'(v.exp) : model_dot(v.dimen, 16'(v.a), 16'(v.b), 16'(v.s));
        for (int i = 0; i < len; i++) exp_q.push_back(16'(v.a) + 16'(i));
        for (int i = 0; i < len; i++) exp_q.push_back(16'(16'(v.b) + 16'(i) * 16'(v.s)));
        @(negedge clk);
        addr_q.delete(); mac_cnt = 0; done_cnt = 0;
        dimen = 2'(v.dimen); a_base = 16'(v.a); b_base = 16'(v.b); b_stride = 16'(v.s);
        start = 1; ack = (v.ack_dly == 0);
        @(negedge clk);
        n = 1;
        start = 0;
        chk("busy_after_start", busy, 1);
        while (!bus.out_ready && n < 4 + 7 * len + 20) begin
            start = v.flags[0] && (n == 5 || n == 4 + 6 * len);
            if (v.flags[0] && n == 5) a_base = a_base + 16'h100;
            @(negedge clk);
            n++;
            if (v.flags[0] && (n == 6 || n == 5 + 6 * len)) chk("busy_ignored_start", busy, 1);
        end
        start = 0;
        chk("out_ready_cycle", n, 4 + 7 * len);
        if (!bus.out_ready) begin
            rst_n = 0; #1 rst_n = 1;
            return;
        end
        chk("result", acc, want);
        held = acc; bad = 0;
        for (int j = 0; j < v.ack_dly; j++) begin
            if (!bus.out_ready || acc !== held || done) bad++;
            @(negedge clk);
        end
        if (v.ack_dly > 0) chk("backpressure_hold", bad, 0);
        chk("ready_in_ack_cycle", bus.out_ready, 1);
        ack = 1;
        @(negedge clk);
        chk("done_pulse", done, 1);
        start = v.flags[1];
        @(negedge clk);
        start = 0; ack = 0;
        chk("busy_drop", {busy, done}, 0);
        if (v.flags[1]) begin
            @(negedge clk);
            chk("fin_start_ignored", busy, 0);
        end
        chk("mem_rd_count", addr_q.size(), 2 * len);
        chk("mac_ctrl_count", mac_cnt, len);
        chk("done_count", done_cnt, 1);
        bad = 0; first = -1;
        for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++)
            if (addr_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (bad != 0) $display("FAIL addr_seq: element %0d got %0h expected %0h", first, addr_q[first], exp_q[first]);
        checks++;
        if (bad != 0) errors++;
    endtask

    vec_t tbl [0:5];
    vec_t rv;

    initial begin
        tbl[0] = '{0, 'h10,  'h20,   4,      0,  0, 76,  1, 0};
        tbl[1] = '{3, 'h100, 'h200,  1,      0,  1, 240, 1, 0};
        tbl[2] = '{2, 'h300, 'h400,  2,      10, 3, 0,   0, 0};
        tbl[3] = '{1, 'h500, 'hFFFE, 1,      0,  2, 4,   1, 0};
        tbl[4] = '{1, 'h600, 'h700,  3,      2,  3, 0,   0, 1};
        tbl[5] = '{0, 'h800, 'h900,  'hFFFF, 1,  3, 0,   0, 2};

        repeat (3) @(negedge clk);
        zero_outputs("reset_state");
        rst_n = 1;

        for (int t = 0; t < 6; t++) run_op(tbl[t]);

        for (int t = 0; t < 6; t++) begin
            rv = '{$urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 65535),
                   $urandom_range(0, 65535), $urandom_range(0, 4), 3, 0, 0, 0};
            run_op(rv);
        end

        rv = '{1, 'hA00, 'hB00, 1, 0, 2, 4, 1, 0};
        fill(rv);
        @(negedge clk);
        dimen = 1; a_base = 16'hA00; b_base = 16'hB00; b_stride = 1; start = 1;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            start = 0;
        end
        chk("pre_reset_phase", {bus.write_mat, bus.mat_mux, bus.latency_counter}, 5'b10_001);
        #2 rst_n = 0;
        #1 zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1;
        run_op(rv);

        chk("rst_add_vs_write_mat", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pe_mac_sequencer.md
# pe_mac_sequencer

Control stage directly upstream of the processing element. On a START request it fetches one A vector and one B vector from word-addressed operand memory, streams both into the PE's operand buffers using the PE's three-phase read-latency protocol, and runs the PE's MAC for the selected dimension. It then holds the PE output valid until the downstream consumer acknowledges it, pulses DONE, and returns to idle.

## Interface
- N, 16: maximum vector length; must be 16.
- ADDR_W, 16: operand memory address width.

- CLK  in  1  clock; all state changes on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only in IDLE.
- DIMEN  in  2  length select, L = 2 << DIMEN (2/4/8/16); latched at START.
- A_BASE  in  ADDR_W  address of A[0]; latched at START.
- B_BASE  in  ADDR_W  address of B[0]; latched at START.
- B_STRIDE  in  ADDR_W  address step between B elements, for column access; latched at START.
- MEM_RD  out  1  memory read strobe.
- MEM_ADDR  out  ADDR_W  memory read address.
- MEM_RDATA  in  32  read data, valid exactly 2 cycles after the MEM_RD cycle.
- DATAIN  out  32  to PE; combinational copy of MEM_RDATA.
- latency_counter  out  3  to PE; read-latency phase 0/1/2.
- WRITE_MAT, MAT_MUX, RST_ADD  out  1 each  to PE; operand-buffer write, buffer select (1 = A), buffer-address clear.
- MAC_CTRL, RST_ACC, RST_PC  out  1 each  to PE; MAC enable, accumulator clear, MAC pointer clear.
- MAC_DONE  in  1  from PE; high when PE MAC pointer equals L.
- DIMEN_PE  out  2  latched DIMEN, driven to PE DIMEN.
- OUT_READY  out  1  to PE and downstream; PE DATAOUT is valid.
- OUT_ACK  in  1  downstream has taken the result.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLR_A, LOAD_A, CLR_B, LOAD_B, MAC, OUT, FIN.
- IDLE: all strobes low. START=1 latches DIMEN, A_BASE, B_BASE and B_STRIDE, then moves to CLR_A.
- CLR_A (1 cycle): RST_ADD=RST_ACC=RST_PC=1, MAT_MUX=1. Next state is LOAD_A. Element index i and latency_counter are cleared.
- LOAD_A (3L cycles): WRITE_MAT=1, MAT_MUX=1. latency_counter cycles 0,1,2,0,…
  - At count 0: MEM_RD=1 and MEM_ADDR = A_BASE + i.
  - At count 2: the PE captures DATAIN, and i increments.
  - After count 2 of element L-1, move to CLR_B.
- CLR_B (1 cycle): RST_ADD=1, MAT_MUX=0, WRITE_MAT=0. i and counter are cleared.
- LOAD_B (3L cycles): same as LOAD_A with MAT_MUX=0 and MEM_ADDR = B_BASE + i*B_STRIDE.
  - The address is kept as a running sum (add B_STRIDE per element); no multiplier.
  - After the last element, move to MAC.
- MAC: MAC_CTRL = (state==MAC) & ~MAC_DONE, which is combinational. Move to OUT on the cycle MAC_DONE=1.
- OUT: OUT_READY=1 while waiting. OUT_ACK=1 moves to FIN. OUT_READY stays high through the ACK cycle.
- FIN (1 cycle): DONE=1, then IDLE.
- Address arithmetic wraps modulo 2^ADDR_W.
- START outside IDLE is ignored. The latched inputs do not change while BUSY.
- MEM_ADDR holds its last value when MEM_RD=0.
- The block never asserts RST_ADD together with WRITE_MAT.

## Timing
- Reset (RSTN=0, at any time including mid-operation): state goes to IDLE immediately.
  - Every output is 0: MEM_RD, MEM_ADDR, latency_counter, WRITE_MAT, MAT_MUX, RST_ADD, MAC_CTRL, RST_ACC, RST_PC, DIMEN_PE, OUT_READY, BUSY, DONE.
  - DATAIN still follows MEM_RDATA.
  - Read data in flight is discarded.
- Let START be sampled at edge k:
  - CLR_A occupies cycle k+1.
  - LOAD_A occupies k+2 … k+1+3L.
  - CLR_B occupies k+2+3L.
  - LOAD_B occupies k+3+3L … k+2+6L.
  - MAC occupies L+1 cycles, with MAC_CTRL high for the first L of them.
  - OUT_READY first rises at cycle k+4+7L.
- With OUT_ACK already high, DONE is at k+5+7L and BUSY drops the following cycle.
- For L=2, OUT_READY rises at k+18.
- MEM_RD is high for exactly 2L cycles per operation, once per element at count 0.
- An OUT_ACK arriving before OUT_READY is ignored.
- START in the same cycle as FIN is ignored. A new operation needs START in IDLE.

## Test plan
- Dot product, length 2:
  - Stimulus: DIMEN=0, A_BASE=0x10 with mem[0x10..11] = 3, 5; B_BASE=0x20, B_STRIDE=4 with mem[0x20] = 7, mem[0x24] = 11; OUT_ACK tied high.
  - Response: B read addresses 0x20, 0x24; OUT_READY at START+18 cycles; PE DATAOUT = 76; DONE one cycle later.
- Full length 16:
  - Stimulus: DIMEN=3, stride 1, A[i]=i, B[i]=2.
  - Response: exactly 32 MEM_RD pulses; MAC_CTRL high 16 cycles; result 240.
- Backpressure:
  - Stimulus: OUT_ACK held low 10 cycles after OUT_READY rises.
  - Response: OUT_READY stays high and the result is stable for all 10 cycles; DONE comes 1 cycle after the ACK.
- Reset mid-operation:
  - Stimulus: RSTN low during LOAD_B element 1.
  - Response: all outputs 0 asynchronously. A following DIMEN=1 run with A=B=[1,1,1,1] returns 4.
- Ignored starts:
  - Stimulus: START pulsed during MAC, and again with changed A_BASE during LOAD_A.
  - Response: no restart and the original addresses are used; BUSY stays high.
- Address wrap:
  - Stimulus: ADDR_W=16, B_BASE=0xFFFE, B_STRIDE=1, DIMEN=1.
  - Response: B addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
